uart_rx_ovs: RTL and testbench

Parametrised oversampling UART receiver, the next generation of the UART RX controller. It takes the serial line plus an oversampling tick from the baud generator. It runs a 2-flop synchroniser, start-bit validation and 3-sample majority voting at mid-bit. Frame length (5–9 data bits), optional parity and 1 or 2 stop bits are configurable, and each frame is delivered as a one-cycle valid strobe with parity, framing and break status to the APB UART register block.

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_rx_ovs_if.sv | 15 +
 rtl/uart_rx_sampler.sv | 49 ++++
 rtl/uart_rx_ovs.sv | 105 ++++++++++
 tb/tb_uart_rx_ovs.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the oversampling UART receiver
//   rx_state_t  receiver FSM encoding
//   clamp_bits  maps an out-of-range frame length to the configured maximum
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK_WAIT} rx_state_t;
  localparam int DATA_W_MIN = 5;
  localparam int DATA_W_MAX = 9;
  localparam int OVS_LO = 8;
  localparam int OVS_HI = 16;
  function automatic logic [3:0] clamp_bits(input logic [3:0] n, input int max_w);
    return (n < 4'(DATA_W_MIN) || n > 4'(max_w)) ? 4'(max_w) : n;
  endfunction
endpackage

// File: rtl/uart_rx_ovs_if.sv
// uart_rx_ovs_if: received-frame bus from the receiver to the APB UART register block
//   oRX_DATA   right-aligned received word
//   oRX_VALID  one-cycle frame strobe
//   oPAR_ERR, oFRM_ERR, oBREAK  status, qualified by oRX_VALID
//   oBUSY      receiver not idle
interface uart_rx_ovs_if #(parameter int DATA_W = 8);
  logic [DATA_W-1:0] oRX_DATA;
  logic oRX_VALID;
  logic oPAR_ERR;
  logic oFRM_ERR;
  logic oBREAK;
  logic oBUSY;
  modport master(output oRX_DATA, oRX_VALID, oPAR_ERR, oFRM_ERR, oBREAK, oBUSY);
  modport slave(input oRX_DATA, oRX_VALID, oPAR_ERR, oFRM_ERR, oBREAK, oBUSY);
endinterface

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: line synchroniser, start-edge detect, tick counter and mid-bit majority vote
//   iCLK, iRESETn  clock, asynchronous active-low reset
//   iUART_RX       asynchronous serial line
//   iRX_TICK       oversampling tick
//   clr            restart the bit timer (start edge accepted)
//   rx_s           synchronised line
//   start_edge     falling edge on the synchronised line
//   bit_val        majority of the three mid-bit samples, valid with bit_rdy
//   bit_rdy        voting tick strobe
//   bit_end        last tick of the bit strobe
module uart_rx_sampler #(parameter int OVS = 16) (
  input  logic iCLK,
  input  logic iRESETn,
  input  logic iUART_RX,
  input  logic iRX_TICK,
  input  logic clr,
  output logic rx_s,
  output logic start_edge,
  output logic bit_val,
  output logic bit_rdy,
  output logic bit_end
);
  localparam int CW = $clog2(OVS);
  localparam logic [CW-1:0] T_LO = CW'(OVS / 2 - 1);
  localparam logic [CW-1:0] T_MID = CW'(OVS / 2);
  localparam logic [CW-1:0] T_HI = CW'(OVS / 2 + 1);
  localparam logic [CW-1:0] T_END = CW'(OVS - 1);
  logic rx_m, rx_d, s_lo, s_mid;
  logic [CW-1:0] tick_cnt;
  // Synchroniser resets low so a line already low at reset release shows no falling edge.
  always_ff @(posedge iCLK or negedge iRESETn)
    if (!iRESETn) begin
      {rx_m, rx_s, rx_d, s_lo, s_mid} <= '0;
      tick_cnt <= '0;
    end else begin
      rx_m <= iUART_RX;
      rx_s <= rx_m;
      rx_d <= rx_s;
      if (iRX_TICK && tick_cnt == T_LO) s_lo <= rx_s;
      if (iRX_TICK && tick_cnt == T_MID) s_mid <= rx_s;
      // A tick coinciding with the start edge is tick 0 of the start bit.
      if (clr) tick_cnt <= CW'(iRX_TICK);
      else if (iRX_TICK) tick_cnt <= tick_cnt == T_END ? '0 : tick_cnt + CW'(1);
    end
  assign start_edge = rx_d & ~rx_s;
  assign bit_val = (s_lo & s_mid) | (s_lo & rx_s) | (s_mid & rx_s);
  assign bit_rdy = iRX_TICK & (tick_cnt == T_HI);
  assign bit_end = iRX_TICK & (tick_cnt == T_END);
endmodule

// File: rtl/uart_rx_ovs.sv
// uart_rx_ovs: oversampling UART receiver, 5..DATA_W data bits, optional parity, 1 or 2 stop bits
//   iCLK, iRESETn   clock, asynchronous active-low reset
//   iUART_RX        serial line, idle high
//   iRX_TICK        OVS x baud tick
//   iDATA_BITS, iPAR_EN, iPAR_ODD, iSTOP2  frame format, latched at the start edge
//   rx              received-frame bus (data, strobe, parity/framing/break, busy)
module uart_rx_ovs
  import uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int OVS = 16
) (
  input  logic iCLK,
  input  logic iRESETn,
  input  logic iUART_RX,
  input  logic iRX_TICK,
  input  logic [3:0] iDATA_BITS,
  input  logic iPAR_EN,
  input  logic iPAR_ODD,
  input  logic iSTOP2,
  uart_rx_ovs_if.master rx
);
  localparam logic [3:0] DW4 = 4'(DATA_W);
  rx_state_t state;
  logic rx_s, start_edge, bit_val, bit_rdy, bit_end;
  logic [3:0] nbits, bit_idx;
  logic [DATA_W-1:0] sh;
  logic par_en, par_odd, stop2, par_err, frm_err, par_bit, stop0, stop_idx;
  logic last_stop, frm_now, brk_now;
  uart_rx_sampler #(.OVS(OVS)) u_sampler (
    .iCLK(iCLK),
    .iRESETn(iRESETn),
    .iUART_RX(iUART_RX),
    .iRX_TICK(iRX_TICK),
    .clr(state == IDLE && start_edge),
    .rx_s(rx_s),
    .start_edge(start_edge),
    .bit_val(bit_val),
    .bit_rdy(bit_rdy),
    .bit_end(bit_end)
  );
  assign last_stop = stop_idx == stop2;
  assign frm_now = frm_err | ~bit_val;
  // Break looks only at the first stop bit; on a single-stop frame that is the bit being voted now.
  assign brk_now = sh == '0 && !(par_en && par_bit) && (stop_idx ? !stop0 : !bit_val);
  assign rx.oBUSY = state != IDLE;
  always_ff @(posedge iCLK or negedge iRESETn)
    if (!iRESETn) begin
      state <= IDLE;
      nbits <= '0;
      bit_idx <= '0;
      sh <= '0;
      {par_en, par_odd, stop2, par_err, frm_err, par_bit, stop0, stop_idx} <= '0;
      rx.oRX_DATA <= '0;
      {rx.oRX_VALID, rx.oPAR_ERR, rx.oFRM_ERR, rx.oBREAK} <= '0;
    end else begin
      {rx.oRX_VALID, rx.oPAR_ERR, rx.oFRM_ERR, rx.oBREAK} <= '0;
      case (state)
        IDLE: if (start_edge) begin
          nbits <= clamp_bits(iDATA_BITS, DATA_W);
          par_en <= iPAR_EN;
          par_odd <= iPAR_ODD;
          stop2 <= iSTOP2;
          bit_idx <= '0;
          sh <= '0;
          {par_err, frm_err, par_bit, stop0, stop_idx} <= '0;
          state <= START;
        end
        START: if (bit_rdy && bit_val) state <= IDLE;
          else if (bit_end) state <= DATA;
        DATA: begin
          // Bits enter at the MSB; the word is right-aligned when it is delivered.
          if (bit_rdy) sh <= {bit_val, sh[DATA_W-1:1]};
          if (bit_end) begin
            bit_idx <= bit_idx + 4'd1;
            if (bit_idx == nbits - 4'd1) state <= par_en ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (bit_rdy) begin
            par_bit <= bit_val;
            par_err <= bit_val != (^sh ^ par_odd);
          end
          if (bit_end) state <= STOP;
        end
        STOP: begin
          if (bit_rdy) begin
            if (!stop_idx) stop0 <= bit_val;
            frm_err <= frm_now;
            if (last_stop) begin
              rx.oRX_VALID <= 1'b1;
              rx.oRX_DATA <= sh >> (DW4 - nbits);
              rx.oPAR_ERR <= par_err;
              rx.oFRM_ERR <= frm_now;
              rx.oBREAK <= brk_now;
              state <= brk_now ? BRK_WAIT : IDLE;
            end
          end
          if (bit_end) stop_idx <= 1'b1;
        end
        BRK_WAIT: if (rx_s) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_rx_ovs.sv
// tb_uart_rx_ovs: randomized self-checking bench for uart_rx_ovs against a frame-level model
module tb_uart_rx_ovs;
  localparam int DATA_W = 8;
  localparam int OVS = 16;
  typedef struct packed {logic [DATA_W-1:0] d; logic pe, fe, br;} strobe_t;
  typedef struct {logic [8:0] d; int n; bit pe, po, s2, bp, gl; logic [1:0] sv;} frame_t;
  logic clk = 1'b0, rst_n = 1'b1, rx_line = 1'b1, tick = 1'b0;
  logic par_en = 1'b0, par_odd = 1'b0, stop2 = 1'b0;
  logic [3:0] dbits = 4'd8;
  int errors = 0, checks = 0, stray = 0;
  strobe_t got[$];
  uart_rx_ovs_if #(.DATA_W(DATA_W)) rxif ();
  uart_rx_ovs #(.DATA_W(DATA_W), .OVS(OVS)) dut (
    .iCLK(clk), .iRESETn(rst_n), .iUART_RX(rx_line), .iRX_TICK(tick),
    .iDATA_BITS(dbits), .iPAR_EN(par_en), .iPAR_ODD(par_odd), .iSTOP2(stop2), .rx(rxif)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (rxif.oRX_VALID) got.push_back({rxif.oRX_DATA, rxif.oPAR_ERR, rxif.oFRM_ERR, rxif.oBREAK});
    else if (rxif.oPAR_ERR | rxif.oFRM_ERR | rxif.oBREAK) stray++;
  end
  task automatic tk(input int n);
    repeat (n) begin
      @(negedge clk) tick = 1'b1;
      @(negedge clk) tick = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask
  task automatic line_bit(input logic v, input bit gl);
    for (int t = 0; t < OVS; t++) begin
      rx_line = (gl && t == OVS / 2) ? ~v : v;
      tk(1);
    end
  endtask
  function automatic int eff_bits(input int n);
    return (n < 5 || n > DATA_W) ? DATA_W : n;
  endfunction
  function automatic frame_t mk(input logic [8:0] d, input int n, input bit pe, po, s2, bp,
                                input logic [1:0] sv, input bit gl);
    frame_t f;
    f.d = d; f.n = n; f.pe = pe; f.po = po; f.s2 = s2; f.bp = bp; f.sv = sv; f.gl = gl;
    return f;
  endfunction
  function automatic logic [8:0] word(input frame_t f);
    return f.d & 9'((1 << eff_bits(f.n)) - 1);
  endfunction
  function automatic logic line_par(input frame_t f);
    return ^word(f) ^ f.po ^ f.bp;
  endfunction
  function automatic strobe_t model(input frame_t f);
    strobe_t e;
    logic [8:0] m;
    m = word(f);
    e.d = m[DATA_W-1:0];
    e.pe = f.pe && (line_par(f) != (^m ^ f.po));
    e.fe = !f.sv[0] || (f.s2 && !f.sv[1]);
    e.br = m == 9'd0 && (!f.pe || !line_par(f)) && !f.sv[0];
    return e;
  endfunction
  task automatic send_frame(input frame_t f, input int gap);
    logic [8:0] m;
    m = word(f);
    dbits = 4'(f.n); par_en = f.pe; par_odd = f.po; stop2 = f.s2;
    line_bit(1'b0, 1'b0);
    dbits = 4'($urandom); par_en = 1'($urandom); par_odd = 1'($urandom); stop2 = 1'($urandom);
    for (int i = 0; i < eff_bits(f.n); i++) line_bit(m[i], f.gl);
    if (f.pe) line_bit(line_par(f), 1'b0);
    line_bit(f.sv[0], 1'b0);
    if (f.s2) line_bit(f.sv[1], 1'b0);
    rx_line = 1'b1;
    tk(gap);
  endtask
  task automatic xfer(input frame_t f, output int cnt, output strobe_t s);
    got.delete();
    send_frame(f, OVS);
    cnt = got.size();
    s = cnt > 0 ? got[0] : '0;
  endtask
  task automatic test_reset;
    rx_line = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (rxif.oRX_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", rxif.oRX_VALID); end
    checks++; if (rxif.oRX_DATA !== '0) begin errors++; $display("FAIL reset_data got %h want 0", rxif.oRX_DATA); end
    checks++; if ({rxif.oPAR_ERR, rxif.oFRM_ERR, rxif.oBREAK} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {rxif.oPAR_ERR, rxif.oFRM_ERR, rxif.oBREAK}); end
    checks++; if (rxif.oBUSY !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", rxif.oBUSY); end
    rst_n = 1'b1;
    tk(OVS);
    checks++; if (rxif.oBUSY !== 1'b0) begin errors++; $display("FAIL low_at_reset busy got %b want 0", rxif.oBUSY); end
    rx_line = 1'b1;
    tk(OVS);
    checks++; if (got.size() != 0) begin errors++; $display("FAIL low_at_reset strobes got %0d want 0", got.size()); end
  endtask
  task automatic test_8n1;
    frame_t f; int cnt; strobe_t s;
    f = mk(9'hA5, 8, 0, 0, 0, 0, 2'b11, 0);
    xfer(f, cnt, s);
    checks++; if (cnt != 1) begin errors++; $display("FAIL 8n1 strobes got %0d want 1", cnt); end
    checks++; if (s !== model(f)) begin errors++; $display("FAIL 8n1 frame got %h want %h", s, model(f)); end
    checks++; if (rxif.oBUSY !== 1'b0) begin errors++; $display("FAIL 8n1 busy got %b want 0", rxif.oBUSY); end
    checks++; if (rxif.oRX_DATA !== 8'hA5) begin errors++; $display("FAIL 8n1 hold got %h want a5", rxif.oRX_DATA); end
  endtask
  task automatic test_7e1;
    frame_t f; int cnt; strobe_t s;
    for (int bp = 0; bp < 2; bp++) begin
      f = mk(9'h07, 7, 1, 0, 0, bp[0], 2'b11, 0);
      xfer(f, cnt, s);
      checks++; if (cnt != 1) begin errors++; $display("FAIL 7e1 strobes got %0d want 1", cnt); end
      checks++; if (s !== model(f)) begin errors++; $display("FAIL 7e1 frame bp=%0d got %h want %h", bp, s, model(f)); end
    end
  endtask
  task automatic test_8n2_frm;
    frame_t f; int cnt; strobe_t s;
    f = mk(9'h3C, 8, 0, 0, 1, 0, 2'b01, 0);
    xfer(f, cnt, s);
    checks++; if (cnt != 1) begin errors++; $display("FAIL 8n2 strobes got %0d want 1", cnt); end
    checks++; if (s !== model(f)) begin errors++; $display("FAIL 8n2 frame got %h want %h", s, model(f)); end
  endtask
  task automatic test_false_start;
    frame_t f; int cnt; strobe_t s;
    got.delete();
    dbits = 4'd8; par_en = 1'b0; stop2 = 1'b0;
    rx_line = 1'b0;
    tk(4);
    rx_line = 1'b1;
    tk(OVS);
    checks++; if (got.size() != 0) begin errors++; $display("FAIL false_start strobes got %0d want 0", got.size()); end
    checks++; if (rxif.oBUSY !== 1'b0) begin errors++; $display("FAIL false_start busy got %b want 0", rxif.oBUSY); end
    f = mk(9'h55, 8, 0, 0, 0, 0, 2'b11, 0);
    xfer(f, cnt, s);
    checks++; if (cnt != 1 || s !== model(f)) begin errors++; $display("FAIL after_false_start got n=%0d %h want n=1 %h", cnt, s, model(f)); end
  endtask
  task automatic test_glitch;
    frame_t f; int cnt; strobe_t s;
    f = mk(9'hF0, 8, 0, 0, 0, 0, 2'b11, 1);
    xfer(f, cnt, s);
    checks++; if (cnt != 1 || s !== model(f)) begin errors++; $display("FAIL glitch got n=%0d %h want n=1 %h", cnt, s, model(f)); end
  endtask
  task automatic test_break;
    frame_t f; int cnt; strobe_t s;
    got.delete();
    dbits = 4'd8; par_en = 1'b0; stop2 = 1'b0;
    rx_line = 1'b0;
    tk(12 * OVS);
    f = mk(9'h00, 8, 0, 0, 0, 0, 2'b00, 0);
    checks++; if (got.size() != 1) begin errors++; $display("FAIL break strobes got %0d want 1", got.size()); end
    s = got.size() > 0 ? got[0] : '0;
    checks++; if (s !== model(f)) begin errors++; $display("FAIL break frame got %h want %h", s, model(f)); end
    checks++; if (rxif.oBUSY !== 1'b1) begin errors++; $display("FAIL break_wait busy got %b want 1", rxif.oBUSY); end
    rx_line = 1'b1;
    tk(OVS);
    checks++; if (got.size() != 1 || rxif.oBUSY !== 1'b0) begin errors++; $display("FAIL break_release got n=%0d busy=%b want n=1 busy=0", got.size(), rxif.oBUSY); end
    f = mk(9'h81, 8, 0, 0, 0, 0, 2'b11, 0);
    xfer(f, cnt, s);
    checks++; if (cnt != 1 || s !== model(f)) begin errors++; $display("FAIL after_break got n=%0d %h want n=1 %h", cnt, s, model(f)); end
  endtask
  task automatic test_reset_mid;
    frame_t f; int cnt; strobe_t s;
    got.delete();
    dbits = 4'd8; par_en = 1'b0; stop2 = 1'b0;
    line_bit(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) line_bit(i == 1, 1'b0);
    checks++; if (rxif.oBUSY !== 1'b1) begin errors++; $display("FAIL mid_busy got %b want 1", rxif.oBUSY); end
    rst_n = 1'b0;
    #1;
    checks++; if ({rxif.oRX_DATA, rxif.oRX_VALID, rxif.oBUSY} !== '0) begin errors++; $display("FAIL mid_reset got data=%h valid=%b busy=%b want 0", rxif.oRX_DATA, rxif.oRX_VALID, rxif.oBUSY); end
    repeat (2) @(negedge clk);
    rx_line = 1'b1;
    rst_n = 1'b1;
    tk(2 * OVS);
    checks++; if (got.size() != 0) begin errors++; $display("FAIL mid_reset strobes got %0d want 0", got.size()); end
    f = mk(9'h12, 8, 0, 0, 0, 0, 2'b11, 0);
    xfer(f, cnt, s);
    checks++; if (cnt != 1 || s !== model(f)) begin errors++; $display("FAIL after_reset got n=%0d %h want n=1 %h", cnt, s, model(f)); end
  endtask
  task automatic test_clamp;
    frame_t f; int cnt; strobe_t s;
    for (int k = 0; k < 2; k++) begin
      f = mk(9'h9B, k == 0 ? 3 : 15, 1, 1, 0, 0, 2'b11, 0);
      xfer(f, cnt, s);
      checks++; if (cnt != 1 || s !== model(f)) begin errors++; $display("FAIL clamp n=%0d got n=%0d %h want n=1 %h", f.n, cnt, s, model(f)); end
    end
  endtask
  task automatic test_back_to_back;
    frame_t a, b;
    got.delete();
    a = mk(9'h6A, 8, 1, 1, 0, 0, 2'b11, 0);
    b = mk(9'h0C, 6, 0, 0, 1, 0, 2'b11, 0);
    send_frame(a, 0);
    send_frame(b, OVS);
    checks++; if (got.size() != 2) begin errors++; $display("FAIL b2b strobes got %0d want 2", got.size()); end
    checks++; if (got.size() == 2 && (got[0] !== model(a) || got[1] !== model(b))) begin errors++; $display("FAIL b2b frames got %h %h want %h %h", got[0], got[1], model(a), model(b)); end
  endtask
  task automatic test_random;
    frame_t f; int cnt; strobe_t s;
    for (int i = 0; i < 20; i++) begin
      f = mk(9'($urandom), $urandom_range(5, DATA_W), 1'($urandom), 1'($urandom), 1'($urandom),
             $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0 ? 2'($urandom) : 2'b11, 1'($urandom));
      xfer(f, cnt, s);
      checks++; if (cnt != 1 || s !== model(f)) begin errors++; $display("FAIL random[%0d] got n=%0d %h want n=1 %h", i, cnt, s, model(f)); end
      rx_line = 1'b1;
      tk(OVS);
    end
  endtask
  task automatic test_flags_idle;
    checks++; if (stray != 0) begin errors++; $display("FAIL flags_without_valid got %0d cycles want 0", stray); end
  endtask
  initial begin
    test_reset;
    test_8n1;
    test_7e1;
    test_8n2_frm;
    test_false_start;
    test_glitch;
    test_break;
    test_reset_mid;
    test_clamp;
    test_back_to_back;
    test_random;
    test_flags_idle;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
